// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared time constants, ASCII codes, reporter FSM encoding and digit helpers
package time_pkg;

  localparam int CLK_HZ_DEFAULT = 1_000_000;
  localparam logic [5:0] FIELD_MAX = 6'd59;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_DASH  = 8'h2D;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam int LINE_LEN = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } txState_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } digits_t;

  function automatic digits_t splitDigits(input logic [5:0] value);
    digits_t d;
    d.tens = 4'(value / 6'd10);
    d.ones = 4'(value % 6'd10);
    return d;
  endfunction

  // Two ASCII characters for one field; out-of-range values render as "--".
  function automatic logic [15:0] fieldChars(input logic [5:0] value);
    digits_t d;
    d = splitDigits(value);
    if (value > FIELD_MAX) begin
      return {ASC_DASH, ASC_DASH};
    end
    return {ASC_ZERO + {4'd0, d.tens}, ASC_ZERO + {4'd0, d.ones}};
  endfunction

endpackage

// File: rtl/time_uart_reporter_uart_tx_byte.sv
// rtl/time_uart_reporter_uart_tx_byte.sv - 8N1 byte serializer with baud counter and 10-bit frame shifter
module uart_tx_byte #(
  parameter int BIT_CYCLES = 104
) (
  input  logic       InClk,
  input  logic       InReset,
  input  logic [7:0] dataByte,
  input  logic       load,
  output logic       tx,
  output logic       bitTick,
  output logic       byteDone
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);

  logic [9:0]       shiftQ;
  logic [CNT_W-1:0] bitCnt;
  logic [3:0]       bitIdx;
  logic             active;

  assign bitTick  = active && (bitCnt == LAST_CNT);
  assign byteDone = bitTick && (bitIdx == 4'd9);
  // Line level is the shifter LSB straight from a flop; the shifter idles at all ones.
  assign tx       = shiftQ[0];

  always_ff @(posedge InClk or negedge InReset) begin
    if (!InReset) begin
      shiftQ <= '1;
      bitCnt <= '0;
      bitIdx <= '0;
      active <= 1'b0;
    end else if (load) begin
      shiftQ <= {1'b1, dataByte, 1'b0};
      bitCnt <= '0;
      bitIdx <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (bitTick) begin
        bitCnt <= '0;
        shiftQ <= {1'b1, shiftQ[9:1]};
        if (bitIdx == 4'd9) begin
          active <= 1'b0;
          bitIdx <= '0;
        end else begin
          bitIdx <= bitIdx + 4'd1;
        end
      end else begin
        bitCnt <= bitCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_uart_reporter.sv
// rtl/time_uart_reporter.sv - sends the latched minutes:seconds as "MM:SS\r\n" over UART 8N1
module time_uart_reporter #(
  parameter int CLK_HZ     = time_pkg::CLK_HZ_DEFAULT,
  parameter int BAUD       = 9600,
  parameter int BIT_CYCLES = CLK_HZ / BAUD
) (
  input  logic       InClk,
  input  logic       InReset,
  input  logic [5:0] InMinute,
  input  logic [5:0] InSecond,
  input  logic       InStart,
  output logic       OutTx,
  output logic       OutBusy,
  output logic       OutDone
);

  import time_pkg::*;

  txState_e    stateQ, stateD;
  logic [2:0]  charIdx, nextIdx, dataCnt;
  logic [15:0] minQ, secQ, newMin, newSec;
  logic [7:0]  loadByte, nextChar;
  logic        load, bitTick, byteDone, lastChar, accept;

  assign newMin   = fieldChars(InMinute);
  assign newSec   = fieldChars(InSecond);
  assign nextIdx  = charIdx + 3'd1;
  assign lastChar = (charIdx == 3'(LINE_LEN - 1));
  assign accept   = (stateQ == ST_IDLE) && InStart;

  always_comb begin
    nextChar = ASC_LF;
    case (nextIdx)
      3'd1:    nextChar = minQ[7:0];
      3'd2:    nextChar = ASC_COLON;
      3'd3:    nextChar = secQ[15:8];
      3'd4:    nextChar = secQ[7:0];
      3'd5:    nextChar = ASC_CR;
      default: nextChar = ASC_LF;
    endcase
  end

  // The first character comes straight from the inputs so its start bit begins the cycle after acceptance.
  always_comb begin
    stateD   = stateQ;
    load     = 1'b0;
    loadByte = newMin[15:8];
    case (stateQ)
      ST_IDLE: begin
        if (InStart) begin
          load   = 1'b1;
          stateD = ST_START;
        end
      end
      ST_START: begin
        if (bitTick) stateD = ST_DATA;
      end
      ST_DATA: begin
        if (bitTick && dataCnt == 3'd7) stateD = ST_STOP;
      end
      ST_STOP: begin
        if (byteDone) begin
          if (lastChar) begin
            stateD = ST_IDLE;
          end else begin
            load     = 1'b1;
            loadByte = nextChar;
            stateD   = ST_START;
          end
        end
      end
      default: stateD = ST_IDLE;
    endcase
  end

  always_ff @(posedge InClk or negedge InReset) begin
    if (!InReset) begin
      stateQ  <= ST_IDLE;
      charIdx <= '0;
      dataCnt <= '0;
      minQ    <= '0;
      secQ    <= '0;
      OutBusy <= 1'b0;
      OutDone <= 1'b0;
    end else begin
      stateQ  <= stateD;
      OutBusy <= (stateD != ST_IDLE);
      OutDone <= (stateQ == ST_STOP) && byteDone && lastChar;
      if (accept) begin
        minQ    <= newMin;
        secQ    <= newSec;
        charIdx <= '0;
      end else if (load) begin
        charIdx <= nextIdx;
      end
      if (stateQ == ST_DATA && bitTick) begin
        dataCnt <= dataCnt + 3'd1;
      end
    end
  end

  uart_tx_byte #(
    .BIT_CYCLES(BIT_CYCLES)
  ) uTxByte (
    .InClk   (InClk),
    .InReset (InReset),
    .dataByte(loadByte),
    .load    (load),
    .tx      (OutTx),
    .bitTick (bitTick),
    .byteDone(byteDone)
  );

endmodule

// File: tb/tb_time_uart_reporter.sv
// tb/tb_time_uart_reporter.sv - randomized self-checking bench for time_uart_reporter with a line-level reference model
module tb_time_uart_reporter;

  logic       clk = 1'b0;
  logic       resetN;
  logic [5:0] minute, second;
  logic       startA, startB;
  logic       txA, busyA, doneA, txB, busyB, doneB;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  time_uart_reporter dutA (
    .InClk(clk), .InReset(resetN), .InMinute(minute), .InSecond(second),
    .InStart(startA), .OutTx(txA), .OutBusy(busyA), .OutDone(doneA)
  );

  time_uart_reporter #(.BIT_CYCLES(2)) dutB (
    .InClk(clk), .InReset(resetN), .InMinute(minute), .InSecond(second),
    .InStart(startB), .OutTx(txB), .OutBusy(busyB), .OutDone(doneB)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fieldChar(input int v, input bit tens);
    if (v > 59) return 8'h2D;
    return 8'(48 + (tens ? v / 10 : v % 10));
  endfunction

  function automatic logic [7:0] refChar(input int m, input int s, input int i);
    case (i)
      0: return fieldChar(m, 1);
      1: return fieldChar(m, 0);
      2: return 8'h3A;
      3: return fieldChar(s, 1);
      4: return fieldChar(s, 0);
      5: return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  function automatic int bitLen(input int sel);
    return sel ? 2 : 104;
  endfunction
  function automatic logic txOf(input int sel);
    return sel ? txB : txA;
  endfunction
  function automatic logic busyOf(input int sel);
    return sel ? busyB : busyA;
  endfunction
  function automatic logic doneOf(input int sel);
    return sel ? doneB : doneA;
  endfunction

  task automatic setStart(input int sel, input logic v);
    if (sel != 0) startB = v;
    else startA = v;
  endtask

  // Leaves the bench at the sampling point of the first cycle after the accepting edge.
  task automatic requestLine(input int sel, input int m, input int s, input bit hold);
    minute = 6'(m);
    second = 6'(s);
    setStart(sel, 1'b1);
    @(negedge clk);
    if (!hold) setStart(sel, 1'b0);
  endtask

  task automatic captureLine(input string tag, input int sel, input int m, input int s, input int poke);
    int b = bitLen(sel);
    int n = 70 * b;
    logic bits [70];
    logic [7:0] got;
    int glitches = 0;
    int busyBad = 0;
    int doneBad = 0;
    int framing = 0;
    for (int c = 1; c <= n; c++) begin
      int k = (c - 1) / b;
      int p = (c - 1) % b;
      if (p == 0) bits[k] = txOf(sel);
      else if (txOf(sel) !== bits[k]) glitches++;
      if (busyOf(sel) !== 1'b1) busyBad++;
      if (doneOf(sel) !== 1'b0) doneBad++;
      if (poke != 0 && c == poke) begin
        setStart(sel, 1'b1);
        second = 6'd50;
      end
      if (poke != 0 && c == poke + 1) setStart(sel, 1'b0);
      @(negedge clk);
    end
    for (int i = 0; i < 7; i++) begin
      if (bits[i*10] !== 1'b0 || bits[i*10+9] !== 1'b1) framing++;
      for (int j = 0; j < 8; j++) got[j] = bits[i*10+1+j];
      checkVal($sformatf("%s char%0d", tag, i), got, refChar(m, s, i));
    end
    checkVal({tag, " framing"}, framing, 0);
    checkVal({tag, " bit stability"}, glitches, 0);
    checkVal({tag, " busy during line"}, busyBad, 0);
    checkVal({tag, " early done"}, doneBad, 0);
    checkVal({tag, " done pulse"}, doneOf(sel), 1);
    checkVal({tag, " busy at done"}, busyOf(sel), 0);
    checkVal({tag, " tx idle at done"}, txOf(sel), 1);
  endtask

  task automatic finishLine(input string tag, input int sel);
    @(negedge clk);
    checkVal({tag, " done single"}, doneOf(sel), 0);
    checkVal({tag, " busy after"}, busyOf(sel), 0);
  endtask

  task automatic quietCycles(input string tag, input int cycles);
    int errs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ({txA, busyA, doneA, txB, busyB, doneB} !== 6'b100100) errs++;
    end
    checkVal(tag, errs, 0);
  endtask

  initial begin
    int errs;
    int m, s, poke;
    resetN = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    minute = 6'd0;
    second = 6'd0;
    #2;
    resetN = 1'b0;
    startA = 1'b1;
    startB = 1'b1;
    minute = 6'd12;
    second = 6'd34;
    quietCycles("reset hold", 8);
    startA = 1'b0;
    startB = 1'b0;
    resetN = 1'b1;
    quietCycles("idle after reset", 300);

    requestLine(0, 12, 34, 0);
    captureLine("12:34", 0, 12, 34, 0);
    finishLine("12:34", 0);
    requestLine(0, 0, 0, 0);
    captureLine("00:00", 0, 0, 0, 0);
    finishLine("00:00", 0);
    requestLine(0, 59, 59, 0);
    captureLine("59:59", 0, 59, 59, 0);
    finishLine("59:59", 0);
    requestLine(0, 63, 7, 0);
    captureLine("63:07", 0, 63, 7, 0);
    finishLine("63:07", 0);

    requestLine(0, 9, 5, 0);
    captureLine("midline", 0, 9, 5, 25 * 104);
    finishLine("midline", 0);

    requestLine(0, 21, 43, 1);
    captureLine("held1", 0, 21, 43, 0);
    minute = 6'd7;
    second = 6'd61;
    @(negedge clk);
    checkVal("held restart tx", txA, 0);
    checkVal("held restart busy", busyA, 1);
    startA = 1'b0;
    captureLine("held2", 0, 7, 61, 0);
    finishLine("held2", 0);

    requestLine(0, 45, 12, 0);
    repeat (35 * 104 - 1) @(negedge clk);
    resetN = 1'b0;
    #1;
    checkVal("abort tx", txA, 1);
    checkVal("abort busy", busyA, 0);
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({txA, busyA, doneA} !== 3'b100) errs++;
    end
    resetN = 1'b1;
    checkVal("abort hold", errs, 0);
    quietCycles("abort no resume", 200);
    requestLine(0, 45, 12, 0);
    captureLine("after abort", 0, 45, 12, 0);
    finishLine("after abort", 0);

    for (int t = 0; t < 24; t++) begin
      m = $urandom_range(0, 63);
      s = $urandom_range(0, 63);
      poke = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 138) : 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      requestLine(1, m, s, 0);
      captureLine($sformatf("rnd%0d %0d:%0d", t, m, s), 1, m, s, poke);
      finishLine($sformatf("rnd%0d", t), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
